// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and glyph table for the seven-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low segment pattern.
// Pure lookup into the shared glyph table.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-seg driver with blanking gap and per-frame snapshot.
// Optional leading-zero suppression when SEG7_LZ_SUPPRESS_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SHOW_TICKS  = 2,
  parameter int BLANK_TICKS = 1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    SCAN_EN,
  input  logic [4*NUM_DIGITS-1:0] DATA,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic [NUM_DIGITS-1:0]   BLANK_IN,
  output logic [6:0]              SEG_N,
  output logic                    DP_N,
  output logic [NUM_DIGITS-1:0]   AN_N,
  output logic [IW-1:0]           DIGIT_IDX
);

  localparam int TMAX =
    (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST =
    (BLANK_TICKS > 0) ? TW'(BLANK_TICKS - 1) : '0;
  localparam bit NO_GAP = (BLANK_TICKS == 0);

  state_t          r_state;
  state_t          w_state_nx;
  logic [TW-1:0]   r_tick;
  logic [TW-1:0]   w_tick_nx;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx_nx;
  logic [IW-1:0]   w_idx_inc;
  logic            w_enter_show;
  logic            w_snap_take;

  logic [4*NUM_DIGITS-1:0] r_snap_data;
  logic [NUM_DIGITS-1:0]   r_snap_dp;
  logic [NUM_DIGITS-1:0]   r_snap_blank;

  logic [3:0]            w_nib;
  logic [6:0]            w_dec;
  logic                  w_dig_off;
  logic                  w_lz;
  logic [6:0]            w_seg;
  logic                  w_dp;
  logic [NUM_DIGITS-1:0] w_an;

  assign w_idx_inc = (r_idx == LAST) ? '0 : r_idx + 1'b1;

  // Scan state register; only moves on scan ticks
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_BLANK;
      r_tick  <= '0;
      r_idx   <= LAST;
    end else if (SCAN_EN) begin
      r_state <= w_state_nx;
      r_tick  <= w_tick_nx;
      r_idx   <= w_idx_nx;
    end
  end

  // Next-state: dwell counting, digit advance, SHOW-entry detect
  always_comb begin
    w_state_nx   = r_state;
    w_tick_nx    = r_tick + 1'b1;
    w_idx_nx     = r_idx;
    w_enter_show = 1'b0;
    unique case (r_state)
      ST_BLANK: begin
        if (NO_GAP || r_tick == BLANK_LAST) begin
          w_state_nx   = ST_SHOW;
          w_tick_nx    = '0;
          w_idx_nx     = w_idx_inc;
          w_enter_show = 1'b1;
        end
      end
      ST_SHOW: begin
        if (r_tick == SHOW_LAST) begin
          w_tick_nx = '0;
          if (NO_GAP) begin
            w_idx_nx     = w_idx_inc;
            w_enter_show = 1'b1;
          end else begin
            w_state_nx = ST_BLANK;
          end
        end
      end
      default: begin
        w_state_nx = ST_BLANK;
        w_tick_nx  = '0;
      end
    endcase
  end

  assign w_snap_take =
    SCAN_EN && w_enter_show && (w_idx_nx == '0);

`ifdef SEG7_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] w_lz_mask;
  logic [NUM_DIGITS-1:0] r_snap_lz;

  // Mask every top digit inside the leading run of zero nibbles
  always_comb begin
    logic zrun;
    zrun      = 1'b1;
    w_lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zrun         = zrun && (DATA[4*i +: 4] == 4'h0);
      w_lz_mask[i] = zrun;
    end
  end

  // Suppression mask is frozen with the rest of the frame
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_snap_lz <= '0;
    end else if (w_snap_take) begin
      r_snap_lz <= w_lz_mask;
    end
  end

  assign w_lz = r_snap_lz[r_idx];
`else
  assign w_lz = 1'b0;
`endif

  // Frame snapshot: freeze the display word at the start of digit 0
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_snap_data  <= '0;
      r_snap_dp    <= '0;
      r_snap_blank <= '0;
    end else if (w_snap_take) begin
      r_snap_data  <= DATA;
      r_snap_dp    <= DP_IN;
      r_snap_blank <= BLANK_IN;
    end
  end

  assign w_nib     = r_snap_data[4*int'(r_idx) +: 4];
  assign w_dig_off = r_snap_blank[r_idx];

  hex_to_seg7 u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  // Pattern for the current state; anode stays driven when digit is blank
  always_comb begin
    w_an  = '1;
    w_seg = SEG_OFF;
    w_dp  = 1'b1;
    if (r_state == ST_SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        w_an[i] = (r_idx != IW'(i));
      end
      if (!w_dig_off) begin
        w_seg = w_lz ? SEG_OFF : w_dec;
        w_dp  = ~r_snap_dp[r_idx];
      end
    end
  end

  // Registered pins, updated on scan ticks only
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      AN_N      <= '1;
      SEG_N     <= SEG_OFF;
      DP_N      <= 1'b1;
      DIGIT_IDX <= LAST;
    end else if (SCAN_EN) begin
      AN_N      <= w_an;
      SEG_N     <= w_seg;
      DP_N      <= w_dp;
      DIGIT_IDX <= r_idx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: table-driven frames with a scoreboard queue.
// A second instance runs with no blanking gap.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        SCAN_EN = 1'b0;
  logic [15:0] DATA = '0;
  logic [3:0]  DP_IN = '0;
  logic [3:0]  BLANK_IN = '0;
  logic [6:0]  SEG_N, SEG0_N;
  logic        DP_N, DP0_N;
  logic [3:0]  AN_N, AN0_N;
  logic [1:0]  DIGIT_IDX, DIGIT0_IDX;

  int errors = 0;
  int checks = 0;
  int pcnt = 0;

  always #5 CLK = ~CLK;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .SHOW_TICKS(2), .BLANK_TICKS(1)
  ) u_dut (
    .CLK(CLK), .RESET(RESET), .SCAN_EN(SCAN_EN),
    .DATA(DATA), .DP_IN(DP_IN), .BLANK_IN(BLANK_IN),
    .SEG_N(SEG_N), .DP_N(DP_N), .AN_N(AN_N),
    .DIGIT_IDX(DIGIT_IDX)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .SHOW_TICKS(2), .BLANK_TICKS(0)
  ) u_dut0 (
    .CLK(CLK), .RESET(RESET), .SCAN_EN(SCAN_EN),
    .DATA(DATA), .DP_IN(DP_IN), .BLANK_IN(BLANK_IN),
    .SEG_N(SEG0_N), .DP_N(DP0_N), .AN_N(AN0_N),
    .DIGIT_IDX(DIGIT0_IDX)
  );

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
    int              gap;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       show;
    logic [1:0] idx;
    logic [3:0] an0;
    logic [1:0] idx0;
    logic       show0;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[6];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Invariant: main DUT never two anodes low; gapless DUT exactly one once lit
  always @(negedge CLK) begin
    if (RESET === 1'b0) begin
      chk("onehot_main", 32'($countones(~AN_N) <= 1), 32'd1);
      if (pcnt >= 3)
        chk("onehot_nogap", 32'($countones(~AN0_N)), 32'd1);
    end
  end

  task automatic check_reset_vals(string tag);
    chk({tag, "_an"}, 32'(AN_N), 32'hF);
    chk({tag, "_seg"}, 32'(SEG_N), 32'h7F);
    chk({tag, "_dp"}, 32'(DP_N), 32'h1);
    chk({tag, "_idx"}, 32'(DIGIT_IDX), 32'h3);
    chk({tag, "_an0"}, 32'(AN0_N), 32'hF);
    chk({tag, "_seg0"}, 32'(SEG0_N), 32'h7F);
    chk({tag, "_idx0"}, 32'(DIGIT0_IDX), 32'h3);
  endtask

  task automatic do_reset(string tag);
    pcnt = 0;
    RESET = 1'b1;
    #1;
    check_reset_vals(tag);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic step(input exp_t e, input int gap);
    exp_t g;
    int d0;
    SCAN_EN = 1'b1;
    pcnt++;
    if (pcnt == 1) begin
      e.an0 = 4'hF;
      e.idx0 = 2'd3;
      e.show0 = 1'b0;
    end else begin
      d0 = ((pcnt - 2) / 2) % 4;
      e.an0 = ~(4'b0001 << d0);
      e.idx0 = 2'(d0);
      e.show0 = 1'b1;
    end
    sbq.push_back(e);
    @(negedge CLK);
    SCAN_EN = 1'b0;
    g = sbq.pop_front();
    chk("an", 32'(AN_N), 32'(g.an));
    chk("seg", 32'(SEG_N), 32'(g.seg));
    chk("dp", 32'(DP_N), 32'(g.dp));
    if (g.show) chk("idx", 32'(DIGIT_IDX), 32'(g.idx));
    chk("an_nogap", 32'(AN0_N), 32'(g.an0));
    if (g.show0) chk("idx_nogap", 32'(DIGIT0_IDX), 32'(g.idx0));
    repeat (gap) @(negedge CLK);
  endtask

  task automatic run_frame(input vec_t v, input int n,
                           input logic tear, input logic [15:0] nd);
    exp_t e;
    int d;
    DATA = v.data;
    DP_IN = v.dp;
    BLANK_IN = v.blank;
    for (int p = 0; p < n; p++) begin
      if (tear && p == 5) DATA = nd;
      e = '{default: '0};
      if (p % 3 == 0) begin
        e.an = 4'hF;
        e.seg = 7'h7F;
        e.dp = 1'b1;
        e.show = 1'b0;
      end else begin
        d = p / 3;
        e.an = ~(4'b0001 << d);
        e.seg = v.seg[d];
        e.dp = v.dpn[d];
        e.idx = 2'(d);
        e.show = 1'b1;
      end
      step(e, v.gap);
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 4'b0000,
                {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 3};
    vecs[1] = '{16'h8888, 4'b0000, 4'b0000,
                {7'h00, 7'h00, 7'h00, 7'h00}, 4'b1111, 1};
    vecs[2] = '{16'hF00F, 4'b0100, 4'b1000,
                {7'h7F, 7'h40, 7'h40, 7'h0E}, 4'b1011, 0};
    vecs[3] = '{16'h89AB, 4'b0000, 4'b0000,
                {7'h00, 7'h10, 7'h08, 7'h03}, 4'b1111, 2};
    vecs[4] = '{16'hCDE5, 4'b1111, 4'b0000,
                {7'h46, 7'h21, 7'h06, 7'h12}, 4'b0000, 0};
    vecs[5] = '{16'h6700, 4'b0001, 4'b0001,
                {7'h02, 7'h78, 7'h40, 7'h7F}, 4'b1111, 1};

    repeat (2) @(negedge CLK);
    do_reset("reset");

    run_frame(vecs[0], 12, 1'b0, 16'h0);
    run_frame(vecs[0], 12, 1'b1, 16'h8888);
    run_frame(vecs[1], 12, 1'b0, 16'h0);
    for (int i = 2; i < 6; i++)
      run_frame(vecs[i], 12, 1'b0, 16'h0);

    run_frame(vecs[0], 8, 1'b0, 16'h0);
    do_reset("midreset");
    run_frame(vecs[3], 12, 1'b0, 16'h0);

`ifdef SEG7_LZ_SUPPRESS_EN
    begin
      vec_t lz;
      lz = '{16'h0050, 4'b0000, 4'b0000,
             {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111, 1};
      run_frame(lz, 12, 1'b0, 16'h0);
      lz = '{16'h0000, 4'b0100, 4'b0000,
             {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1011, 1};
      run_frame(lz, 12, 1'b0, 16'h0);
    end
`endif

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
